// File: rtl/axi_bridge_pkg.sv
// Shared definitions for the sram-to-AXI bridge: BRESP encodings and
// write-tracker error-bit positions.
package axi_bridge_pkg;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_EXOKAY = 2'b01;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    localparam int ERR_RESP  = 0;
    localparam int ERR_ID    = 1;
    localparam int ERR_UNEXP = 2;
    localparam int ERR_OVF   = 3;
    localparam int ERR_W     = 4;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == BRESP_SLVERR) || (resp == BRESP_DECERR);
    endfunction

endpackage

// File: rtl/wr_pend_buf.sv
// In-order pending-write FIFO with per-entry valid bits and a parallel
// tag compare against every live entry; push/pop arrive pre-qualified.
module wr_pend_buf #(
    parameter int ID_W  = 4,
    parameter int DEPTH = 4,
    parameter int TAG_W = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [ID_W-1:0]          push_id,
    input  logic [TAG_W-1:0]         push_tag,
    input  logic                     pop,
    input  logic [TAG_W-1:0]         chk_tag,
    output logic [ID_W-1:0]          head_id,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     full,
    output logic                     empty,
    output logic                     match
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [DEPTH-1:0] vld;
    logic [ID_W-1:0]  id_mem  [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            vld  <= '0;
        end else begin
            if (pop) begin
                vld[rptr] <= 1'b0;
                rptr      <= rptr + 1'b1;
            end
            if (push) begin
                vld[wptr] <= 1'b1;
                wptr      <= wptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload needs no reset: only entries with vld set are ever looked at.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wptr]  <= push_id;
            tag_mem[wptr] <= push_tag;
        end
    end

    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (tag_mem[i] == chk_tag)) begin
                match = 1'b1;
            end
        end
    end

    assign head_id = id_mem[rptr];
    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);

endmodule

// File: rtl/axi_wr_resp_tracker.sv
// Tracks outstanding AXI writes, retires them on B handshakes, flags errors.
// Latency: data_sram_data_ok one cycle after B handshake; rd_hazard combinational.
// Backpressure: wr_full stalls the issuer; bready is high or follows !wr_empty.
module axi_wr_resp_tracker #(
    parameter int ID_W          = 4,
    parameter int DEPTH         = 4,
    parameter int ADDR_W        = 32,
    parameter int HAZ_LSB       = 2,
    parameter bit BREADY_ALWAYS = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_issue,
    input  logic [ID_W-1:0]          wr_issue_id,
    input  logic [ADDR_W-1:0]        wr_issue_addr,
    output logic                     wr_full,
    output logic                     wr_empty,
    output logic [$clog2(DEPTH):0]   pend_cnt,
    input  logic [ID_W-1:0]          bid,
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready,
    output logic                     data_sram_data_ok,
    input  logic [ADDR_W-1:0]        rd_chk_addr,
    output logic                     rd_hazard,
    output logic                     wr_err,
    output logic [3:0]               wr_err_code
);

    import axi_bridge_pkg::*;

    localparam int TAG_W = ADDR_W - HAZ_LSB;

    logic             push;
    logic             pop;
    logic             b_hs;
    logic             buf_match;
    logic [ID_W-1:0]  head_id;
    logic [TAG_W-1:0] issue_tag;
    logic [TAG_W-1:0] chk_tag;
    logic             unused_low_bits;

    assign issue_tag       = wr_issue_addr[ADDR_W-1:HAZ_LSB];
    assign chk_tag         = rd_chk_addr[ADDR_W-1:HAZ_LSB];
    assign unused_low_bits = ^{wr_issue_addr[HAZ_LSB-1:0], rd_chk_addr[HAZ_LSB-1:0]};

    // bready depends only on registered state, never on bvalid.
    assign bready = BREADY_ALWAYS ? 1'b1 : !wr_empty;
    assign b_hs   = bvalid && bready;
    assign push   = wr_issue && !wr_full;
    assign pop    = b_hs && !wr_empty;

    wr_pend_buf #(
        .ID_W  (ID_W),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_id  (wr_issue_id),
        .push_tag (issue_tag),
        .pop      (pop),
        .chk_tag  (chk_tag),
        .head_id  (head_id),
        .cnt      (pend_cnt),
        .full     (wr_full),
        .empty    (wr_empty),
        .match    (buf_match)
    );

    // The in-flight issue is bypassed so a same-cycle load sees it.
    assign rd_hazard = buf_match || (push && (issue_tag == chk_tag));

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_sram_data_ok <= 1'b0;
            wr_err_code       <= '0;
        end else begin
            data_sram_data_ok <= pop;
            if (pop && resp_is_err(bresp)) wr_err_code[ERR_RESP]  <= 1'b1;
            if (pop && (bid != head_id))   wr_err_code[ERR_ID]    <= 1'b1;
            if (b_hs && wr_empty)          wr_err_code[ERR_UNEXP] <= 1'b1;
            if (wr_issue && wr_full)       wr_err_code[ERR_OVF]   <= 1'b1;
        end
    end

    assign wr_err = |wr_err_code;

endmodule

// File: tb/tb_axi_wr_resp_tracker.sv
// Bench for axi_wr_resp_tracker: directed scenarios plus a randomized run
// against a queue-based model of the pending-write tracker.
module tb_axi_wr_resp_tracker;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_issue;
    logic [3:0]  wr_issue_id;
    logic [31:0] wr_issue_addr;
    logic        wr_full, wr_empty;
    logic [2:0]  pend_cnt;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        data_sram_data_ok;
    logic [31:0] rd_chk_addr;
    logic        rd_hazard, wr_err;
    logic [3:0]  wr_err_code;

    logic        z_bvalid;
    logic        z_full, z_empty, z_bready, z_ok, z_haz, z_err;
    logic [2:0]  z_pend;
    logic [3:0]  z_err_code;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
    } ent_t;

    ent_t       mq[$];
    logic [3:0] m_err = 4'b0;
    logic       m_ok  = 1'b0;
    logic       exp_haz, obs_haz;

    always #5 clk = ~clk;

    axi_wr_resp_tracker #(.ID_W(4), .DEPTH(DEPTH), .ADDR_W(32), .HAZ_LSB(2), .BREADY_ALWAYS(1'b1)) dut (
        .clk(clk), .reset(reset), .wr_issue(wr_issue), .wr_issue_id(wr_issue_id),
        .wr_issue_addr(wr_issue_addr), .wr_full(wr_full), .wr_empty(wr_empty), .pend_cnt(pend_cnt),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .data_sram_data_ok(data_sram_data_ok), .rd_chk_addr(rd_chk_addr), .rd_hazard(rd_hazard),
        .wr_err(wr_err), .wr_err_code(wr_err_code)
    );

    axi_wr_resp_tracker #(.ID_W(4), .DEPTH(DEPTH), .ADDR_W(32), .HAZ_LSB(2), .BREADY_ALWAYS(1'b0)) dut_z (
        .clk(clk), .reset(reset), .wr_issue(1'b0), .wr_issue_id(4'h0),
        .wr_issue_addr(32'h0), .wr_full(z_full), .wr_empty(z_empty), .pend_cnt(z_pend),
        .bid(4'h0), .bresp(2'b00), .bvalid(z_bvalid), .bready(z_bready),
        .data_sram_data_ok(z_ok), .rd_chk_addr(32'h0), .rd_hazard(z_haz),
        .wr_err(z_err), .wr_err_code(z_err_code)
    );

    task automatic set_in(input logic iss, input logic [3:0] iid, input logic [31:0] iaddr,
                          input logic bv, input logic [3:0] b_id, input logic [1:0] b_resp,
                          input logic [31:0] chk);
        wr_issue = iss; wr_issue_id = iid; wr_issue_addr = iaddr;
        bvalid = bv; bid = b_id; bresp = b_resp; rd_chk_addr = chk;
    endtask

    // Advances one clock; captures the pre-edge hazard and updates the model.
    task automatic tick();
        bit mfull, mpush, mpop;
        #1;
        mfull   = (mq.size() == DEPTH);
        mpush   = wr_issue && !mfull;
        mpop    = bvalid && (mq.size() != 0);
        exp_haz = 1'b0;
        foreach (mq[i]) if ((mq[i].addr >> 2) == (rd_chk_addr >> 2)) exp_haz = 1'b1;
        if (mpush && ((wr_issue_addr >> 2) == (rd_chk_addr >> 2))) exp_haz = 1'b1;
        obs_haz = rd_hazard;
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            m_err = 4'b0;
            m_ok  = 1'b0;
        end else begin
            m_ok = mpop;
            if (mpop) begin
                if (bid != mq[0].id) m_err[1] = 1'b1;
                if (bresp >= 2'd2)   m_err[0] = 1'b1;
                void'(mq.pop_front());
            end
            if (bvalid && !mpop)     m_err[2] = 1'b1;
            if (wr_issue && mfull)   m_err[3] = 1'b1;
            if (mpush) mq.push_back('{wr_issue_id, wr_issue_addr});
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        z_bvalid = 1'b0;
        do_reset();
        n_cmp++; if (pend_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_pend got=%0d exp=0", pend_cnt); end
        n_cmp++; if (wr_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", wr_empty); end
        n_cmp++; if (wr_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", wr_full); end
        n_cmp++; if (data_sram_data_ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok got=%b exp=0", data_sram_data_ok); end
        n_cmp++; if (wr_err_code !== 4'b0) begin n_fail++; $display("FAIL reset_err_code got=%b exp=0000", wr_err_code); end
        n_cmp++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", wr_err); end
        n_cmp++; if (bready !== 1'b1) begin n_fail++; $display("FAIL reset_bready got=%b exp=1", bready); end
        n_cmp++; if (z_bready !== 1'b0) begin n_fail++; $display("FAIL reset_bready_z got=%b exp=0", z_bready); end
    endtask

    task automatic test_in_order();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 4'(i + 1), 32'h100 + 32'(4 * i), 0, 0, 0, 0);
            tick();
            n_cmp++; if (pend_cnt !== 3'(i + 1)) begin n_fail++; $display("FAIL inorder_fill_pend got=%0d exp=%0d", pend_cnt, i + 1); end
        end
        n_cmp++; if (data_sram_data_ok !== 1'b0) begin n_fail++; $display("FAIL inorder_ok_idle got=%b exp=0", data_sram_data_ok); end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 1, 4'(i + 1), 2'b00, 0);
            tick();
            n_cmp++; if (data_sram_data_ok !== 1'b1) begin n_fail++; $display("FAIL inorder_ok%0d got=%b exp=1", i, data_sram_data_ok); end
            n_cmp++; if (pend_cnt !== 3'(2 - i)) begin n_fail++; $display("FAIL inorder_drain_pend got=%0d exp=%0d", pend_cnt, 2 - i); end
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (data_sram_data_ok !== 1'b0) begin n_fail++; $display("FAIL inorder_ok_after got=%b exp=0", data_sram_data_ok); end
        n_cmp++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL inorder_err got=%b exp=0", wr_err); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 4'(i), 32'h300 + 32'(4 * i), 0, 0, 0, 0);
            tick();
        end
        n_cmp++; if (wr_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got=%b exp=1", wr_full); end
        n_cmp++; if (pend_cnt !== 3'd4) begin n_fail++; $display("FAIL ovf_pend4 got=%0d exp=4", pend_cnt); end
        set_in(1, 4'd9, 32'h400, 0, 0, 0, 32'h400);
        tick();
        n_cmp++; if (obs_haz !== 1'b0) begin n_fail++; $display("FAIL ovf_no_bypass got=%b exp=0", obs_haz); end
        n_cmp++; if (wr_err_code !== 4'b1000) begin n_fail++; $display("FAIL ovf_code got=%b exp=1000", wr_err_code); end
        n_cmp++; if (pend_cnt !== 3'd4) begin n_fail++; $display("FAIL ovf_dropped got=%0d exp=4", pend_cnt); end
        set_in(1, 4'd10, 32'h404, 1, 4'd0, 2'b00, 0);
        tick();
        n_cmp++; if (pend_cnt !== 3'd3) begin n_fail++; $display("FAIL ovf_pushpop_pend got=%0d exp=3", pend_cnt); end
        n_cmp++; if (data_sram_data_ok !== 1'b1) begin n_fail++; $display("FAIL ovf_pushpop_ok got=%b exp=1", data_sram_data_ok); end
        n_cmp++; if (wr_err_code !== 4'b1000) begin n_fail++; $display("FAIL ovf_pushpop_code got=%b exp=1000", wr_err_code); end
        n_cmp++; if (wr_full !== 1'b0) begin n_fail++; $display("FAIL ovf_unfull got=%b exp=0", wr_full); end
        for (int i = 1; i < 4; i++) begin
            set_in(0, 0, 0, 1, 4'(i), 2'b01, 0);
            tick();
        end
        n_cmp++; if (wr_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained got=%b exp=1", wr_empty); end
        n_cmp++; if (wr_err_code !== 4'b1000) begin n_fail++; $display("FAIL ovf_exokay_code got=%b exp=1000", wr_err_code); end
        do_reset();
    endtask

    task automatic test_hazard();
        set_in(1, 4'd1, 32'h200, 0, 0, 0, 32'h202);
        tick();
        n_cmp++; if (obs_haz !== 1'b1) begin n_fail++; $display("FAIL haz_bypass got=%b exp=1", obs_haz); end
        set_in(0, 0, 0, 0, 0, 0, 32'h202);
        #1;
        n_cmp++; if (rd_hazard !== 1'b1) begin n_fail++; $display("FAIL haz_202 got=%b exp=1", rd_hazard); end
        rd_chk_addr = 32'h204;
        #1;
        n_cmp++; if (rd_hazard !== 1'b0) begin n_fail++; $display("FAIL haz_204 got=%b exp=0", rd_hazard); end
        set_in(0, 0, 0, 1, 4'd1, 2'b00, 32'h202);
        tick();
        n_cmp++; if (obs_haz !== 1'b1) begin n_fail++; $display("FAIL haz_pop_cycle got=%b exp=1", obs_haz); end
        set_in(0, 0, 0, 0, 0, 0, 32'h202);
        #1;
        n_cmp++; if (rd_hazard !== 1'b0) begin n_fail++; $display("FAIL haz_after_pop got=%b exp=0", rd_hazard); end
    endtask

    task automatic test_errors();
        set_in(1, 4'd5, 32'h500, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 4'd6, 2'b10, 0);
        tick();
        n_cmp++; if (data_sram_data_ok !== 1'b1) begin n_fail++; $display("FAIL err_ok got=%b exp=1", data_sram_data_ok); end
        n_cmp++; if (wr_err_code !== 4'b0011) begin n_fail++; $display("FAIL err_code got=%b exp=0011", wr_err_code); end
        n_cmp++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL err_flag got=%b exp=1", wr_err); end
        set_in(1, 4'd7, 32'h504, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 4'd7, 2'b00, 0);
        tick();
        n_cmp++; if (wr_err_code !== 4'b0011) begin n_fail++; $display("FAIL err_sticky got=%b exp=0011", wr_err_code); end
        do_reset();
    endtask

    task automatic test_unexpected();
        set_in(0, 0, 0, 1, 4'd3, 2'b00, 0);
        z_bvalid = 1'b1;
        tick();
        z_bvalid = 1'b0;
        n_cmp++; if (data_sram_data_ok !== 1'b0) begin n_fail++; $display("FAIL unexp_ok got=%b exp=0", data_sram_data_ok); end
        n_cmp++; if (wr_err_code !== 4'b0100) begin n_fail++; $display("FAIL unexp_code got=%b exp=0100", wr_err_code); end
        n_cmp++; if (z_bready !== 1'b0) begin n_fail++; $display("FAIL unexp_z_bready got=%b exp=0", z_bready); end
        n_cmp++; if (z_err_code !== 4'b0 || z_ok !== 1'b0) begin n_fail++; $display("FAIL unexp_z got=%b/%b exp=0000/0", z_err_code, z_ok); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        set_in(1, 4'd1, 32'h600, 0, 0, 0, 0);
        tick();
        set_in(1, 4'd2, 32'h604, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 32'h600);
        tick();
        reset = 1'b1;
        #1;
        n_cmp++; if (pend_cnt !== 3'd0 || wr_empty !== 1'b1) begin n_fail++; $display("FAIL mid_reset_cnt got=%0d/%b exp=0/1", pend_cnt, wr_empty); end
        n_cmp++; if (rd_hazard !== 1'b0) begin n_fail++; $display("FAIL mid_reset_haz got=%b exp=0", rd_hazard); end
        n_cmp++; if (data_sram_data_ok !== 1'b0 || wr_err_code !== 4'b0 || bready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_outs got=ok%b code%b bready%b exp=ok0 code0000 bready1", data_sram_data_ok, wr_err_code, bready);
        end
    endtask

    task automatic test_random();
        logic [3:0] b_id;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 79) != 0);
            if (mq.size() != 0 && $urandom_range(0, 9) != 0) b_id = mq[0].id;
            else b_id = 4'($urandom_range(0, 15));
            set_in($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), 32'($urandom_range(0, 63)),
                   $urandom_range(0, 9) < 4, b_id, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)));
            tick();
            n_cmp++; if (obs_haz !== exp_haz) begin n_fail++; $display("FAIL rnd_haz c=%0d got=%b exp=%b", c, obs_haz, exp_haz); end
            n_cmp++; if (data_sram_data_ok !== m_ok) begin n_fail++; $display("FAIL rnd_ok c=%0d got=%b exp=%b", c, data_sram_data_ok, m_ok); end
            n_cmp++; if (pend_cnt !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_pend c=%0d got=%0d exp=%0d", c, pend_cnt, mq.size()); end
            n_cmp++; if (wr_full !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full c=%0d got=%b", c, wr_full); end
            n_cmp++; if (wr_empty !== (mq.size() == 0)) begin n_fail++; $display("FAIL rnd_empty c=%0d got=%b", c, wr_empty); end
            n_cmp++; if (wr_err_code !== m_err) begin n_fail++; $display("FAIL rnd_code c=%0d got=%b exp=%b", c, wr_err_code, m_err); end
            n_cmp++; if (wr_err !== (|m_err)) begin n_fail++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, wr_err, |m_err); end
        end
    endtask

    initial begin
        reset = 1'b0;
        z_bvalid = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_in_order();
        test_overflow();
        test_hazard();
        test_errors();
        test_unexpected();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_wr_resp_tracker.md
# axi_wr_resp_tracker

Parametrised write-response tracker for the sram-to-AXI bridge; replaces the single-write B-channel stub. Records every write issued on AW/W in an in-order pending buffer, consumes AXI B responses, produces one `data_sram_data_ok` pulse per completed write, and flags protocol or slave errors. Also exposes a read-after-write hazard check, so the read path stalls a load whose address matches a still-pending store.

## Interface
- `ID_W`, 4: width of AXI write ID.
- `DEPTH`, 4: maximum outstanding writes; power of two, ≥2.
- `ADDR_W`, 32: address width.
- `HAZ_LSB`, 2: low address bits ignored in the hazard compare (word granularity).
- `BREADY_ALWAYS`, 1: 1 = `bready` tied high; 0 = `bready` = !empty.

- `clk` in 1: single clock; everything is sampled on the rising edge.
- `reset` in 1: synchronous, active-low.
- `wr_issue` in 1: one write has had both its AW and W handshakes completed this cycle.
- `wr_issue_id` in ID_W: AWID of the issued write.
- `wr_issue_addr` in ADDR_W: AWADDR of the issued write.
- `wr_full` out 1: pending count == DEPTH; the issuer must not assert `wr_issue`.
- `wr_empty` out 1: pending count == 0.
- `pend_cnt` out $clog2(DEPTH)+1: number of pending writes.
- `bid` in 4 (ID_W): AXI BID.
- `bresp` in 2: AXI BRESP.
- `bvalid` in 1: AXI BVALID.
- `bready` out 1: AXI BREADY.
- `data_sram_data_ok` out 1: one-cycle pulse per retired write.
- `rd_chk_addr` in ADDR_W: address of the read being checked for a hazard.
- `rd_hazard` out 1: combinational; the read address matches a pending write.
- `wr_err` out 1: sticky; OR of `wr_err_code`.
- `wr_err_code` out 4: sticky error bits.

## Operation
- Pending buffer: circular FIFO of DEPTH entries, each {valid, id, addr}. Write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is a separate register.
- Push: on `wr_issue && !wr_full`.
- Pop: on B handshake (`bvalid && bready`) with count ≠ 0. The popped entry's valid bit is cleared.
- Simultaneous push and pop: both take effect and the count is unchanged.
  - At count == DEPTH, the push is still rejected, because `wr_full` was high at the start of the cycle.
- ID check: if `bid` ≠ head.id, set `wr_err_code[1]`. The entry is popped regardless.
- Response check: if `bresp` is SLVERR (2'b10) or DECERR (2'b11), set `wr_err_code[0]`. OKAY and EXOKAY count as success.
- Unexpected response: B handshake while empty (possible only when BREADY_ALWAYS=1) sets `wr_err_code[2]`. No pop and no `data_ok`.
- Overflow: `wr_issue` while `wr_full` sets `wr_err_code[3]`. The write is dropped.
- `data_sram_data_ok` pulses once per pop, including pops that raised an error.
- Hazard check: `rd_hazard` = any valid entry with addr[ADDR_W-1:HAZ_LSB] equal to `rd_chk_addr`[ADDR_W-1:HAZ_LSB].
  - Also true when `wr_issue && !wr_full` this cycle and `wr_issue_addr` matches (bypass).
  - The entry being popped this cycle still counts toward the hazard.
- Error bits are cleared only by reset.

## Timing
- Reset (`reset`==0 at a clock edge) produces:
  - pointers = 0, count = 0, all valid bits = 0;
  - `data_sram_data_ok` = 0, `wr_err_code` = 0, `wr_err` = 0;
  - `wr_empty` = 1, `wr_full` = 0, `pend_cnt` = 0;
  - `bready` = 1 if BREADY_ALWAYS else 0.
- Reset asserted mid-operation discards all pending entries. B responses arriving afterwards for writes issued before the reset are flagged as unexpected (when BREADY_ALWAYS=1) or are not accepted (when BREADY_ALWAYS=0).
- `data_sram_data_ok` is registered: it is high exactly in the cycle after the B handshake. Back-to-back handshakes give back-to-back pulses.
- `wr_full`, `wr_empty` and `pend_cnt` come from registers and update the cycle after a push or pop.
- `bready` is registered-derived (from count) and has no combinational path from `bvalid`.
- `rd_hazard` is combinational from `rd_chk_addr`, `wr_issue` and `wr_issue_addr`.
- Error bits are set in the cycle after the offending event.
- Throughput is one push and one pop per cycle.

## Structure
- Shared package `axi_bridge_pkg`:
  - BRESP encodings OKAY/EXOKAY/SLVERR/DECERR;
  - error-bit indices ERR_RESP=0, ERR_ID=1, ERR_UNEXP=2, ERR_OVF=3.
- One sub-module, `wr_pend_buf`: the DEPTH-entry FIFO with per-entry valid and a parallel address-compare output. The top level holds the B-handshake logic, the error logic and the `data_ok` register.

## Test plan
- Issue 3 writes (ids 1, 2, 3; addrs 0x100, 0x104, 0x108), then return B OKAY for ids 1, 2, 3 → three `data_ok` pulses, each one cycle after its handshake; `pend_cnt` goes 3→0; `wr_err`=0.
- Fill to DEPTH=4, then assert `wr_issue` again → `wr_full`=1, the write is dropped, `wr_err_code`=4'b1000. Issue and B handshake in the same cycle while full → `pend_cnt` goes to 3, and the issue is also dropped and flagged.
- Pending write at 0x200 → `rd_chk_addr` 0x202 gives `rd_hazard`=1; 0x204 gives 0; after the B handshake (cycle +1), 0x202 gives 0.
- B with `bresp`=2'b10 and `bid` ≠ head id → `data_ok` still pulses; `wr_err_code`=4'b0011, and it stays set after further OKAY responses.
- BREADY_ALWAYS=1, empty, `bvalid`=1 → no `data_ok`, `wr_err_code[2]`=1. With BREADY_ALWAYS=0 → `bready`=0 and no error.
- 2 writes pending, then `reset`=0 for one cycle → count 0, `wr_empty`=1, `rd_hazard`=0, all outputs at their reset values.
